// File: rtl/nn_pkg.sv
// Shared definitions for MAC feeders: sequencer state encoding and datapath constants.
package nn_pkg;

  localparam int unsigned DATA_W = 8;
  // Cycles of zero pairs needed to push the last product through the MAC pipeline.
  localparam int unsigned MAC_PIPE_FLUSH = 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    READ
  } state_t;

endpackage

// File: rtl/neuron_weight_regfile.sv
// Per-neuron weight storage: synchronous write, asynchronous read, synchronous clear.
module neuron_weight_regfile #(
  parameter int unsigned N_INPUTS = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [N_INPUTS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_INPUTS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (32'(waddr) < N_INPUTS)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/neuron_sequencer.sv
// Feeds weight/input pairs into one MAC_Core, flushes its pipeline and captures the dot product.
module neuron_sequencer #(
  parameter int unsigned N_INPUTS = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  input  logic              w_we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] mac_weight,
  output logic [DATA_W-1:0] mac_in,
  output logic              mac_reset,
  output logic              mac_oe,
  input  logic [DATA_W-1:0] mac_out
);

  import nn_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_INPUTS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              done_d;
  logic [DATA_W-1:0] result_d;
  logic [DATA_W-1:0] w_rdata;
  logic              w_wen;

  // Weights are frozen whenever an evaluation is in flight.
  assign w_wen = w_we && (state_q == IDLE);

  neuron_weight_regfile #(
    .N_INPUTS (N_INPUTS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W)
  ) u_weights (
    .clk   (clk),
    .reset (reset),
    .we    (w_wen),
    .waddr (w_addr),
    .wdata (w_data),
    .raddr (idx_q),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done    <= done_d;
      result  <= result_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    result_d   = result;
    busy       = 1'b1;
    in_addr    = '0;
    mac_weight = '0;
    mac_in     = '0;
    mac_oe     = 1'b0;
    mac_reset  = reset;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        mac_reset = 1'b1;
        idx_d     = '0;
        state_d   = FEED;
      end
      FEED: begin
        in_addr    = idx_q;
        mac_weight = w_rdata;
        mac_in     = in_data;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = FLUSH;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      FLUSH: begin
        state_d = READ;
      end
      // mac_out is only trusted here; elsewhere the MAC leaves it floating.
      READ: begin
        mac_oe   = 1'b1;
        result_d = mac_out;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
